timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_pkg.sv | 27 ++
 rtl/timer_channel.sv | 128 ++++++++++++
 rtl/timer_bank.sv | 112 +++++++++++
 tb/tb_timer_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register map within a channel,
// CTRL bit positions and the location of the STATUS word.
package timer_bank_pkg;

    // Word offset of a register within its channel's 4-word block.
    typedef enum logic [1:0] {
        REG_RELOAD   = 2'd0,
        REG_COUNT    = 2'd1,
        REG_CTRL     = 2'd2,
        REG_PRESCALE = 2'd3
    } reg_sel_e;

    localparam int unsigned REGS_PER_CH = 4;

    // CTRL bit positions.
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IE      = 1;
    localparam int unsigned CTRL_ONESHOT = 2;
    localparam int unsigned CTRL_PEND    = 3;
    localparam int unsigned CTRL_W       = 4;

    // STATUS sits directly after the last channel block.
    function automatic logic [7:0] status_word(input int unsigned n_ch);
        return 8'(n_ch * REGS_PER_CH);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up-counter with reload, CTRL flags.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   wr_i, sel_i        write strobe for this channel and register select
//   wdata_i            bus write data
//   pend_clr_i         PEND clear request from the STATUS register
//   reload_o, count_o  RELOAD and COUNT register values
//   presc_o            PRESCALE register value
//   ctrl_o             {PEND, ONESHOT, IE, EN}
//   irq_o              PEND AND IE
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_i,
    input  logic [1:0]         sel_i,
    input  logic [31:0]        wdata_i,
    input  logic               pend_clr_i,
    output logic [CNT_W-1:0]   reload_o,
    output logic [CNT_W-1:0]   count_o,
    output logic [PRESC_W-1:0] presc_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic               irq_o
);

    reg_sel_e sel;
    assign sel = reg_sel_e'(sel_i);

    logic [CNT_W-1:0]   reload_q, reload_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [PRESC_W-1:0] presc_q,  presc_d;
    logic [PRESC_W-1:0] psc_q,    psc_d;
    logic               en_q, en_d;
    logic               ie_q, ie_d;
    logic               os_q, os_d;
    logic               pend_q, pend_d;

    logic wr_reload, wr_count, wr_ctrl, wr_presc;
    logic tick, expire, pend_clr, en_rise_wr;

    always_comb begin
        wr_reload  = wr_i && (sel == REG_RELOAD);
        wr_count   = wr_i && (sel == REG_COUNT);
        wr_ctrl    = wr_i && (sel == REG_CTRL);
        wr_presc   = wr_i && (sel == REG_PRESCALE);

        tick       = en_q && (psc_q == presc_q);
        expire     = tick && (&count_q);
        pend_clr   = pend_clr_i || (wr_ctrl && wdata_i[CTRL_PEND]);
        en_rise_wr = wr_ctrl && wdata_i[CTRL_EN] && !en_q;

        reload_d = reload_q;
        count_d  = count_q;
        presc_d  = presc_q;
        psc_d    = psc_q;
        en_d     = en_q;
        ie_d     = ie_q;
        os_d     = os_q;

        if (wr_reload) reload_d = wdata_i[CNT_W-1:0];
        if (wr_presc)  presc_d  = wdata_i[PRESC_W-1:0];

        if (wr_ctrl) begin
            en_d = wdata_i[CTRL_EN];
            ie_d = wdata_i[CTRL_IE];
            os_d = wdata_i[CTRL_ONESHOT];
        end
        // One-shot expiry disables the channel even against a same-cycle EN write.
        if (expire && os_q) en_d = 1'b0;

        if (en_rise_wr) begin
            psc_d = '0;
        end else if (en_q) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end

        if (wr_count) begin
            count_d = wdata_i[CNT_W-1:0];
        end else if (expire) begin
            count_d = reload_q;
        end else if (tick) begin
            count_d = count_q + 1'b1;
        end

        // Set wins over clear.
        pend_d = expire || (pend_q && !pend_clr);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            reload_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            psc_q    <= '0;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            os_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            psc_q    <= psc_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            os_q     <= os_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        ctrl_o               = '0;
        ctrl_o[CTRL_EN]      = en_q;
        ctrl_o[CTRL_IE]      = ie_q;
        ctrl_o[CTRL_ONESHOT] = os_q;
        ctrl_o[CTRL_PEND]    = pend_q;
    end

    assign reload_o = reload_q;
    assign count_o  = count_q;
    assign presc_o  = presc_q;
    assign irq_o    = pend_q && ie_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH independent prescaled timers behind a simple memory-mapped bus.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   peri_addr             high when the bus targets this block
//   Address, Write_data   byte address (bits [9:2] decoded) and write data
//   MemRead, MemWrite     bus strobes
//   Read_data             registered read data, 0 when no read was issued
//   irq_vec, irq          per-channel PEND AND IE, and its OR
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            peri_addr,
    input  logic [31:0]     Address,
    input  logic [31:0]     Write_data,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic [31:0]     Read_data,
    output logic [N_CH-1:0] irq_vec,
    output logic            irq
);

    logic [7:0] word;
    logic [5:0] word_ch;
    logic [1:0] word_reg;
    logic       wr_en, rd_en, status_hit;
    logic       unused_addr_bits;

    assign word             = Address[9:2];
    assign word_ch          = word[7:2];
    assign word_reg         = word[1:0];
    assign wr_en            = MemWrite && peri_addr;
    assign rd_en            = MemRead && peri_addr;
    assign status_hit       = (word == status_word(N_CH));
    assign unused_addr_bits = ^{Address[31:10], Address[1:0]};

    logic [N_CH-1:0] status_clr;
    assign status_clr = (wr_en && status_hit) ? Write_data[N_CH-1:0] : '0;

    logic [CNT_W-1:0]   reload_a [N_CH];
    logic [CNT_W-1:0]   count_a  [N_CH];
    logic [PRESC_W-1:0] presc_a  [N_CH];
    logic [CTRL_W-1:0]  ctrl_a   [N_CH];
    logic [N_CH-1:0]    ch_wr;
    logic [N_CH-1:0]    pend_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [5:0] IDX = 6'(i);

        assign ch_wr[i] = wr_en && (word_ch == IDX);

        timer_channel #(
            .CNT_W  (CNT_W),
            .PRESC_W(PRESC_W)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (reset),
            .wr_i      (ch_wr[i]),
            .sel_i     (word_reg),
            .wdata_i   (Write_data),
            .pend_clr_i(status_clr[i]),
            .reload_o  (reload_a[i]),
            .count_o   (count_a[i]),
            .presc_o   (presc_a[i]),
            .ctrl_o    (ctrl_a[i]),
            .irq_o     (irq_vec[i])
        );

        assign pend_vec[i] = ctrl_a[i][CTRL_PEND];
    end

    assign irq = |irq_vec;

    logic [31:0] rdata_mux;
    logic [31:0] Read_data_q, Read_data_d;

    always_comb begin
        rdata_mux = '0;
        if (status_hit) begin
            rdata_mux[N_CH-1:0] = pend_vec;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (32'(word_ch) == c) begin
                    case (reg_sel_e'(word_reg))
                        REG_RELOAD:   rdata_mux[CNT_W-1:0]   = reload_a[c];
                        REG_COUNT:    rdata_mux[CNT_W-1:0]   = count_a[c];
                        REG_CTRL:     rdata_mux[CTRL_W-1:0]  = ctrl_a[c];
                        REG_PRESCALE: rdata_mux[PRESC_W-1:0] = presc_a[c];
                        default:      rdata_mux              = '0;
                    endcase
                end
            end
        end
        Read_data_d = rd_en ? rdata_mux : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            Read_data_q <= '0;
        end else begin
            Read_data_q <= Read_data_d;
        end
    end

    assign Read_data = Read_data_q;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned PRESC_W = 8;
    localparam int unsigned STATUS  = N_CH * 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            peri_addr = 1'b0;
    logic [31:0]     Address = '0;
    logic [31:0]     Write_data = '0;
    logic            MemRead = 1'b0;
    logic            MemWrite = 1'b0;
    logic [31:0]     Read_data;
    logic [N_CH-1:0] irq_vec;
    logic            irq;

    int unsigned total = 0;
    int unsigned bad   = 0;

    timer_bank #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .peri_addr (peri_addr),
        .Address   (Address),
        .Write_data(Write_data),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Read_data (Read_data),
        .irq_vec   (irq_vec),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model state, one entry per channel.
    bit [31:0] m_reload [N_CH];
    bit [31:0] m_count  [N_CH];
    bit [7:0]  m_presc  [N_CH];
    bit [7:0]  m_psc    [N_CH];
    bit        m_en     [N_CH];
    bit        m_ie     [N_CH];
    bit        m_os     [N_CH];
    bit        m_pend   [N_CH];
    bit [31:0] m_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_read(input int unsigned word);
        bit [31:0] v;
        int unsigned ch;
        v = '0;
        if (word < N_CH * 4) begin
            ch = word / 4;
            case (word % 4)
                0: v = m_reload[ch];
                1: v = m_count[ch];
                2: v = {28'd0, m_pend[ch], m_os[ch], m_ie[ch], m_en[ch]};
                default: v = {24'd0, m_presc[ch]};
            endcase
        end else if (word == STATUS) begin
            for (int c = 0; c < N_CH; c++) v[c] = m_pend[c];
        end
        return v;
    endfunction

    // Advances the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int unsigned word;
        bit [31:0]   wd;
        bit          wr, tick, expiry, clr, old_os;
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                m_reload[c] = 0; m_count[c] = 0; m_presc[c] = 0; m_psc[c] = 0;
                m_en[c] = 0; m_ie[c] = 0; m_os[c] = 0; m_pend[c] = 0;
            end
            m_rd = 0;
            return;
        end
        word = int'(Address[9:2]);
        wd   = Write_data;
        m_rd = (MemRead && peri_addr) ? model_read(word) : 32'd0;
        wr   = MemWrite && peri_addr;
        for (int c = 0; c < N_CH; c++) begin
            tick   = m_en[c] && (m_psc[c] == m_presc[c]);
            expiry = tick && (m_count[c] == 32'hFFFF_FFFF);
            old_os = m_os[c];

            if (wr && word == c * 4 + 2 && wd[0] && !m_en[c]) m_psc[c] = 0;
            else if (m_en[c]) m_psc[c] = tick ? 8'd0 : m_psc[c] + 8'd1;

            if (wr && word == c * 4 + 1) m_count[c] = wd;
            else if (expiry)             m_count[c] = m_reload[c];
            else if (tick)               m_count[c] = m_count[c] + 1;

            clr = (wr && word == c * 4 + 2 && wd[3]) || (wr && word == STATUS && wd[c]);
            if (expiry)   m_pend[c] = 1;
            else if (clr) m_pend[c] = 0;

            if (wr && word == c * 4 + 2) begin
                m_en[c] = wd[0];
                m_ie[c] = wd[1];
                m_os[c] = wd[2];
            end
            if (expiry && old_os) m_en[c] = 0;

            if (wr && word == c * 4)     m_reload[c] = wd;
            if (wr && word == c * 4 + 3) m_presc[c]  = wd[7:0];
        end
    endtask

    task automatic tick_cycle();
        bit [N_CH-1:0] exp_vec;
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) exp_vec[c] = m_pend[c] && m_ie[c];
        check_eq("rdata", Read_data, m_rd);
        check_eq("irq_vec", 32'(irq_vec), 32'(exp_vec));
        check_eq("irq", 32'(irq), 32'(|exp_vec));
        peri_addr  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic bus_wr(input int unsigned word, input logic [31:0] data);
        peri_addr  = 1'b1;
        MemWrite   = 1'b1;
        Address    = 32'(word) << 2;
        Write_data = data;
        tick_cycle();
    endtask

    task automatic bus_rd(input int unsigned word, output logic [31:0] data);
        peri_addr = 1'b1;
        MemRead   = 1'b1;
        Address   = 32'(word) << 2;
        tick_cycle();
        data = Read_data;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rnd;
        int unsigned w;

        // Reset state
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        check_eq("rst_rdata", Read_data, 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        bus_rd(2, rd);
        check_eq("rst_ctrl0", rd, 32'd0);

        // ch0 expiry timing with IE
        bus_wr(0, 32'hFFFF_FFFC);
        bus_wr(1, 32'hFFFF_FFFC);
        bus_wr(3, 32'd0);
        bus_wr(2, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            tick_cycle();
            check_eq("exp_irq_timing", 32'(irq), (k == 4) ? 32'd1 : 32'd0);
        end
        bus_rd(1, rd);
        check_eq("exp_reload_count", rd, 32'hFFFF_FFFC);
        bus_wr(2, 32'h8);

        // ch1 prescaler of 3
        bus_wr(7, 32'd3);
        bus_wr(5, 32'd0);
        bus_wr(6, 32'h1);
        idle(4);
        bus_rd(5, rd);
        check_eq("presc_cnt1", rd, 32'd1);
        idle(3);
        bus_rd(5, rd);
        check_eq("presc_cnt2", rd, 32'd2);
        bus_wr(6, 32'h0);

        // ch2 one-shot
        bus_wr(8, 32'h10);
        bus_wr(9, 32'hFFFF_FFFE);
        bus_wr(11, 32'd0);
        bus_wr(10, 32'h5);
        idle(4);
        bus_rd(10, rd);
        check_eq("oneshot_ctrl", rd, 32'hC);
        bus_rd(9, rd);
        check_eq("oneshot_count", rd, 32'h10);
        check_eq("oneshot_irq", 32'(irq), 32'd0);
        idle(3);
        bus_rd(9, rd);
        check_eq("oneshot_frozen", rd, 32'h10);
        bus_wr(STATUS, 32'h4);

        // Expiry coinciding with a STATUS clear
        bus_wr(1, 32'hFFFF_FFFE);
        bus_wr(2, 32'h3);
        idle(1);
        bus_wr(STATUS, 32'h1);
        check_eq("setwins_irq", 32'(irq), 32'd1);
        bus_rd(STATUS, rd);
        check_eq("setwins_status", rd, 32'h1);
        bus_wr(2, 32'h2);
        check_eq("pend_kept_irq", 32'(irq), 32'd1);
        bus_wr(STATUS, 32'h1);
        check_eq("status_clr_irq", 32'(irq), 32'd0);

        // COUNT write on a tick cycle; unmapped offset
        bus_wr(15, 32'd0);
        bus_wr(13, 32'd0);
        bus_wr(14, 32'h1);
        bus_wr(13, 32'h10);
        bus_rd(13, rd);
        check_eq("cntwr_priority", rd, 32'h10);
        bus_rd(STATUS + 1, rd);
        check_eq("unmapped_rd", rd, 32'd0);
        bus_wr(STATUS + 1, 32'hFFFF_FFFF);
        bus_rd(STATUS + 1, rd);
        check_eq("unmapped_wr", rd, 32'd0);
        bus_wr(14, 32'h0);

        // Reset while counting
        bus_wr(1, 32'hFFFF_FFF0);
        bus_wr(2, 32'h3);
        idle(2);
        reset = 1'b0;
        tick_cycle();
        reset = 1'b1;
        for (int unsigned a = 0; a <= STATUS; a++) begin
            bus_rd(a, rd);
            check_eq("midrst_reg", rd, 32'd0);
        end
        idle(30);
        check_eq("midrst_irq", 32'(irq), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 3) == 0) w = $urandom_range(0, 255);
            else                           w = $urandom_range(0, STATUS + 1);
            case ($urandom_range(0, 3))
                0: Write_data = 32'hFFFF_FFFF - $urandom_range(0, 6);
                1: Write_data = $urandom();
                2: Write_data = $urandom_range(0, 3);
                default: Write_data = $urandom_range(0, 15);
            endcase
            rnd        = $urandom();
            Address    = {rnd[31:10], w[7:0], rnd[1:0]};
            peri_addr  = ($urandom_range(0, 7) != 0);
            MemWrite   = ($urandom_range(0, 2) == 0);
            MemRead    = ($urandom_range(0, 1) == 0);
            reset      = ($urandom_range(0, 299) != 0);
            tick_cycle();
            reset = 1'b1;
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
